// File: rtl/dm_ctrl_if.sv
// One requester port of the data-memory controller: the request, its attributes,
// and the registered completion (rdata/ack/err).
interface dm_ctrl_if #(
  parameter int AW = 10
);
  logic          req;
  logic          we;
  logic [1:0]    size;
  logic          sext;
  logic [AW-1:0] addr;
  logic [31:0]   wdata;
  logic [31:0]   rdata;
  logic          ack;
  logic          err;

  modport master (output req, we, size, sext, addr, wdata, input rdata, ack, err);
  modport slave  (input req, we, size, sext, addr, wdata, output rdata, ack, err);
endinterface

// File: rtl/dm_ctrl.sv
// Round-robin data-memory access controller for two requesters: word-aligned
// accesses, byte/half/word loads with extension, sub-word stores by read-modify-write.
module dm_ctrl #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  dm_ctrl_if.slave      a,
  dm_ctrl_if.slave      b,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dout,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state, state_nx;
  logic          grant_b, last_b;
  logic          l_we, l_sext, l_err;
  logic [1:0]    l_size;
  logic [AW-1:0] l_addr;
  logic [31:0]   l_wdata;

  logic          any_req, pick_b, s_misal;
  logic [1:0]    s_size;
  logic [AW-1:0] s_addr;
  logic [31:0]   shifted, load_val, lane_mask, lane_data, merged;
  logic [4:0]    lane_sh;

  // Arbitration: with both requesting, the port that did not win last time goes.
  always_comb begin
    any_req = a.req | b.req;
    pick_b  = b.req & (~a.req | ~last_b);
    s_size  = pick_b ? b.size : a.size;
    s_addr  = pick_b ? b.addr : a.addr;
    s_misal = (s_size == 2'b11) ||
              (s_size == 2'b01 && s_addr[0]) ||
              (s_size == 2'b10 && s_addr[1:0] != 2'b00);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (any_req) state_nx = ACCESS;
      ACCESS:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_b <= 1'b0;
      last_b  <= 1'b1;
      l_we    <= 1'b0;
      l_sext  <= 1'b0;
      l_err   <= 1'b0;
      l_size  <= '0;
      l_addr  <= '0;
      l_wdata <= '0;
    end else if (state == IDLE && any_req) begin
      grant_b <= pick_b;
      last_b  <= pick_b;
      l_we    <= pick_b ? b.we    : a.we;
      l_sext  <= pick_b ? b.sext  : a.sext;
      l_wdata <= pick_b ? b.wdata : a.wdata;
      l_size  <= s_size;
      l_addr  <= s_addr;
      l_err   <= s_misal;
    end
  end

  // Lane shift in bits derived from the byte offset; half stores use addr[1] only.
  always_comb begin
    lane_sh = {l_addr[1:0], 3'b000};
    shifted = mem_dout >> lane_sh;
    case (l_size)
      2'b00:   load_val = {{24{l_sext & shifted[7]}},  shifted[7:0]};
      2'b01:   load_val = {{16{l_sext & shifted[15]}}, shifted[15:0]};
      default: load_val = mem_dout;
    endcase
    if (l_size == 2'b00) begin
      lane_mask = 32'h0000_00FF << lane_sh;
      lane_data = {24'h0, l_wdata[7:0]} << lane_sh;
    end else begin
      lane_mask = 32'h0000_FFFF << {l_addr[1], 4'b0000};
      lane_data = {16'h0, l_wdata[15:0]} << {l_addr[1], 4'b0000};
    end
    merged = (mem_dout & ~lane_mask) | lane_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a.rdata <= '0;
      b.rdata <= '0;
    end else if (state == ACCESS && (!l_we || l_err)) begin
      if (grant_b) b.rdata <= l_err ? '0 : load_val;
      else         a.rdata <= l_err ? '0 : load_val;
    end
  end

  always_comb begin
    busy     = (state != IDLE);
    mem_addr = {l_addr[AW-1:2], 2'b00};
    mem_we   = (state == ACCESS) && l_we && !l_err;
    mem_din  = '0;
    if (mem_we) mem_din = (l_size == 2'b10) ? l_wdata : merged;
    a.ack    = (state == DONE) && !grant_b;
    b.ack    = (state == DONE) && grant_b;
    a.err    = a.ack && l_err;
    b.err    = b.ack && l_err;
  end
endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: byte-array memory, byte-level reference model, directed
// scenarios followed by randomized single-port traffic.
module tb_dm_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dm_ctrl_if #(.AW(10)) a_if ();
  dm_ctrl_if #(.AW(10)) b_if ();

  logic [9:0]  mem_addr;
  logic [31:0] mem_din, mem_dout;
  logic        mem_we, busy;

  dm_ctrl #(.AW(10), .DW(32)) dut (
    .clk(clk), .rst(rst), .a(a_if), .b(b_if),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .busy(busy)
  );

  logic [7:0] mem     [1024];
  logic [7:0] ref_mem [1024];
  int we_total = 0;
  int checks = 0;
  int errors = 0;

  assign mem_dout = {mem[{mem_addr[9:2], 2'd3}], mem[{mem_addr[9:2], 2'd2}],
                     mem[{mem_addr[9:2], 2'd1}], mem[{mem_addr[9:2], 2'd0}]};

  always @(posedge clk) begin
    if (mem_we) begin
      we_total <= we_total + 1;
      for (int i = 0; i < 4; i++) mem[int'(mem_addr[9:2]) * 4 + i] <= mem_din[i*8 +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_mis(input logic [1:0] sz, input logic [9:0] ad);
    return (sz == 2'd3) || (sz == 2'd1 && ad % 2 != 0) || (sz == 2'd2 && ad % 4 != 0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit sx, input logic [9:0] ad);
    int n = 1 << sz;
    longint v = 0;
    for (int i = 0; i < n; i++) v += longint'(ref_mem[int'(ad) + i]) << (8 * i);
    if (sx && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return 32'(v);
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [9:0] ad, input logic [31:0] wd);
    int n = 1 << sz;
    for (int i = 0; i < n; i++) ref_mem[int'(ad) + i] = 8'(wd >> (8 * i));
  endtask

  function automatic logic [31:0] word_at(input bit from_ref, input logic [9:0] ad);
    logic [31:0] w = '0;
    for (int i = 0; i < 4; i++)
      w[i*8 +: 8] = from_ref ? ref_mem[int'(ad[9:2]) * 4 + i] : mem[int'(ad[9:2]) * 4 + i];
    return w;
  endfunction

  function automatic logic [31:0] rdata_of(input bit pb);
    return pb ? b_if.rdata : a_if.rdata;
  endfunction
  function automatic logic ack_of(input bit pb);
    return pb ? b_if.ack : a_if.ack;
  endfunction
  function automatic logic err_of(input bit pb);
    return pb ? b_if.err : a_if.err;
  endfunction

  task automatic drive(input bit pb, input bit rq, input bit we, input logic [1:0] sz,
                       input bit sx, input logic [9:0] ad, input logic [31:0] wd);
    if (pb) begin
      b_if.req = rq; b_if.we = we; b_if.size = sz; b_if.sext = sx; b_if.addr = ad; b_if.wdata = wd;
    end else begin
      a_if.req = rq; a_if.we = we; a_if.size = sz; a_if.sext = sx; a_if.addr = ad; a_if.wdata = wd;
    end
  endtask

  // One complete transaction on one port, checked against the reference model.
  task automatic do_op(input bit pb, input bit we, input logic [1:0] sz, input bit sx,
                       input logic [9:0] ad, input logic [31:0] wd, output logic [31:0] got);
    int lat = 0;
    int w0;
    bit e_err = ref_mis(sz, ad);
    logic [31:0] e_rd = '0;
    logic [31:0] other = rdata_of(!pb);
    @(negedge clk);
    if (!we && !e_err) e_rd = ref_load(sz, sx, ad);
    w0 = we_total;
    drive(pb, 1'b1, we, sz, sx, ad, wd);
    do begin
      @(negedge clk);
      lat++;
    end while (!ack_of(pb) && lat < 10);
    check("ack_latency", 32'(lat), 32'd2);
    check("err", {31'd0, err_of(pb)}, {31'd0, e_err});
    check("other_ack", {31'd0, ack_of(!pb)}, 32'd0);
    check("other_rdata_hold", rdata_of(!pb), other);
    if (!we) check("rdata", rdata_of(pb), e_rd);
    check("we_pulses", 32'(we_total - w0), (we && !e_err) ? 32'd1 : 32'd0);
    if (we && !e_err) ref_store(sz, ad, wd);
    check("mem_word", word_at(1'b0, ad), word_at(1'b1, ad));
    got = rdata_of(pb);
    drive(pb, 1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int cyc, last_cyc, n;
    bit exp_b, re_a, re_b;

    for (int i = 0; i < 1024; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 32'd0);
    rst = 1'b1;
    #12;
    check("rst_a_rdata", a_if.rdata, 32'd0);
    check("rst_b_rdata", b_if.rdata, 32'd0);
    check("rst_acks", {30'd0, a_if.ack, b_if.ack}, 32'd0);
    check("rst_errs", {30'd0, a_if.err, b_if.err}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", {22'd0, mem_addr}, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Word store/load
    do_op(1'b0, 1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, got);
    do_op(1'b0, 1'b0, 2'd2, 1'b0, 10'h010, 32'd0, got);
    check("t1_lw", got, 32'hDEADBEEF);

    // Byte store, signed/unsigned byte loads
    do_op(1'b0, 1'b1, 2'd0, 1'b0, 10'h011, 32'h00000080, got);
    do_op(1'b0, 1'b0, 2'd0, 1'b1, 10'h011, 32'd0, got);
    check("t2_lb", got, 32'hFFFFFF80);
    do_op(1'b0, 1'b0, 2'd0, 1'b0, 10'h011, 32'd0, got);
    check("t2_lbu", got, 32'h00000080);
    do_op(1'b0, 0, 2'd2, 1'b0, 10'h010, 32'd0, got);
    check("t2_lw", got, 32'hDEAD80EF);

    // Half store, half load, misaligned half store
    do_op(1'b0, 1'b1, 2'd1, 1'b0, 10'h012, 32'h00001234, got);
    do_op(1'b0, 1'b0, 2'd2, 1'b0, 10'h010, 32'd0, got);
    check("t3_lw", got, 32'h123480EF);
    do_op(1'b0, 1'b0, 2'd1, 1'b1, 10'h012, 32'd0, got);
    check("t3_lh", got, 32'h00001234);
    do_op(1'b0, 1'b1, 2'd1, 1'b0, 10'h013, 32'h0000ABCD, got);
    do_op(1'b0, 1'b0, 2'd2, 1'b0, 10'h010, 32'd0, got);
    check("t3_lw_unchanged", got, 32'h123480EF);

    // Top of memory, misaligned word load
    do_op(1'b1, 1'b1, 2'd2, 1'b0, 10'h3FC, 32'h89ABCDEF, got);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 10'h3FC, 32'd0, got);
    check("t5_lw_top", got, 32'h89ABCDEF);
    do_op(1'b1, 1'b0, 2'd2, 1'b0, 10'h3FE, 32'd0, got);
    check("t5_lw_mis", got, 32'd0);

    // Reset while a store is in ACCESS
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 10'h020, 32'hCAFEF00D);
    @(posedge clk);
    #2;
    check("t6_busy_access", {31'd0, busy}, 32'd1);
    check("t6_we_access", {31'd0, mem_we}, 32'd1);
    rst = 1'b1;
    #1;
    check("t6_we_drop", {31'd0, mem_we}, 32'd0);
    check("t6_busy_drop", {31'd0, busy}, 32'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t6_no_ack", {31'd0, a_if.ack}, 32'd0);
    end
    check("t6_mem", word_at(1'b0, 10'h020), word_at(1'b1, 10'h020));

    // Both ports requesting continuously after reset: A first, then alternate
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 10'h010, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 10'h3FC, 32'd0);
    cyc = 0; last_cyc = -1; n = 0; exp_b = 1'b0; re_a = 1'b0; re_b = 1'b0;
    while (n < 6 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (re_a) begin a_if.req = 1'b1; re_a = 1'b0; end
      if (re_b) begin b_if.req = 1'b1; re_b = 1'b0; end
      if (a_if.ack || b_if.ack) begin
        check("arb_a_ack", {31'd0, a_if.ack}, {31'd0, !exp_b});
        check("arb_b_ack", {31'd0, b_if.ack}, {31'd0, exp_b});
        check("arb_spacing", 32'(cyc - last_cyc), (last_cyc < 0) ? 32'd3 : 32'd3);
        if (b_if.ack) begin
          check("arb_b_rdata", b_if.rdata, ref_load(2'd2, 1'b0, 10'h3FC));
          b_if.req = 1'b0; re_b = 1'b1;
        end else begin
          check("arb_a_rdata", a_if.rdata, ref_load(2'd2, 1'b0, 10'h010));
          a_if.req = 1'b0; re_a = 1'b1;
        end
        last_cyc = cyc;
        exp_b = !exp_b;
        n++;
      end
      if (last_cyc < 0 && cyc == 1) last_cyc = -1;
    end
    check("arb_grants", 32'(n), 32'd6);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 32'd0);
    repeat (3) @(negedge clk);

    // Randomized single-port traffic over a small window
    for (int i = 0; i < 60; i++) begin
      do_op(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
            10'(10'h100 + $urandom_range(0, 63)), $urandom, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dm_ctrl.md
Name: dm_ctrl

Overview:
- Data-memory access controller between two requesters and the word-wide, byte-addressed 1 KB data memory.
- Port A is the CPU load/store unit; port B is the debug/loader port.
- The memory has a combinational read, a synchronous write, little-endian byte lanes (byte k on bits 8k+7:8k) and a 10-bit byte address.
- The block arbitrates round-robin, word-aligns accesses, performs byte/half/word loads with optional sign extension and sub-word stores via read-modify-write, and flags misaligned accesses.

Parameters:
AW, 10, memory byte-address width
DW, 32, data width (fixed 32; lane logic assumes 4 bytes)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous active-high reset
a_req  in  1  port A request, held high until a_ack
a_we  in  1  1 = store, 0 = load
a_size  in  2  00 byte, 01 half, 10 word, 11 illegal (treated as misaligned)
a_sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend
a_addr  in  AW  byte address
a_wdata  in  32  store data, right-justified
a_rdata  out  32  load result, registered, valid with a_ack
a_ack  out  1  one-cycle completion pulse
a_err  out  1  misaligned flag, valid with a_ack
b_req, b_we, b_size, b_sext, b_addr, b_wdata, b_rdata, b_ack, b_err  (same as port A, for port B)
mem_addr  out  AW  word-aligned address ({addr[AW-1:2],2'b00})
mem_din  out  32  write data to memory
mem_we  out  1  memory write enable
mem_dout  in  32  combinational memory read data
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (async, immediate):
  - state = IDLE, last_grant = B.
  - All rdata = 0, ack = 0, err = 0, mem_we = 0, mem_addr = 0, mem_din = 0.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE. Fixed 3-cycle transaction; at most one transaction per 3 cycles.
- IDLE:
  - If any req is high, grant one port: if both, the port != last_grant; else the requesting port.
  - Latch we/size/sext/addr/wdata and the grant; set last_grant; go to ACCESS.
  - No request: stay in IDLE.
- Misalignment (computed at latch):
  - half with addr[0]=1, word with addr[1:0]!=0, or size=11 -> err.
- ACCESS:
  - mem_addr = latched word address.
  - Load: extract lane(s) from mem_dout per addr[1:0]/size, extend per sext, register into the granted port's rdata.
  - Word store: mem_we = 1, mem_din = wdata.
  - Byte/half store: mem_we = 1, mem_din = mem_dout with the addressed lane(s) replaced by wdata[7:0]/[15:0]. Other lanes unchanged.
  - err: mem_we = 0 and the granted rdata is set to 0.
  - mem_we is combinational from state/latched fields and is high only in ACCESS.
  - Go to DONE.
- DONE:
  - Granted port's ack = 1 for exactly this cycle; err = latched misalignment flag.
  - Go to IDLE.
- Requester handshake:
  - Must drop req at the edge where ack is sampled.
  - A req high in IDLE is always a new request.
- Non-granted port:
  - Its req stays pending; it wins the next IDLE arbitration.
  - Its rdata holds its previous value.
- rdata holds its value until the next load completes on that port. Stores leave rdata unchanged.
- Address wrap: none; word index addr[AW-1:2] covers memory exactly.
- Latched fields are immune to requester input changes during ACCESS/DONE.
- rst during ACCESS: state returns to IDLE immediately and mem_we falls.
  - No write occurs at the following edge; no ack is issued.
  - The requester must re-issue.

Test Plan:
1. A: sw 0xDEADBEEF @0x010, then lw @0x010 -> ack 2 cycles after req sampled in IDLE; rdata=0xDEADBEEF, err=0; mem_we high exactly 1 cycle.
2. A: sb 0x80 @0x011; lb (sext=1) @0x011 -> 0xFFFFFF80; lbu -> 0x00000080; lw @0x010 -> 0xDEAD80EF.
3. A: sh 0x1234 @0x012 -> lw @0x010 = 0x123480EF; lh (sext=1) @0x012 -> 0x00001234; sh @0x013 -> err=1, no mem_we, word unchanged.
4. After reset, a_req and b_req high together and each re-requests after every ack -> grants A,B,A,B; each ack spaced 3 cycles; B's pending req never lost.
5. Word store @0x3FC, lw -> data correct; lw @0x3FE -> err=1, rdata=0.
6. rst pulsed while state=ACCESS of sw 0xCAFEF00D @0x020 -> mem_we drops immediately; memory word unchanged; no ack; busy=0.
